// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter slice: FSM state and index-width helper.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Client-side and spi_master-side signals of the SPI arbiter.
interface spi_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            ack;
   logic                          err;
   logic [DATA_WIDTH-1:0]         rx_data;
   logic                          m_start;
   logic [DATA_WIDTH-1:0]         m_tx_data;
   logic [DATA_WIDTH-1:0]         m_rx_data;
   logic                          m_done;
   logic                          m_busy;
   logic                          m_cs_n;
   logic [NUM_REQ-1:0]            spi_cs_n;

   modport master (
      input  req, req_data, m_rx_data, m_done, m_busy, m_cs_n,
      output grant, ack, err, rx_data, m_start, m_tx_data, spi_cs_n
   );

   modport slave (
      output req, req_data, m_rx_data, m_done, m_busy, m_cs_n,
      input  grant, ack, err, rx_data, m_start, m_tx_data, spi_cs_n
   );
endinterface

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      win,
   output logic               any
);

   logic [IW-1:0] idx;

   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin share of one spi_master among NUM_REQ clients.
// Optional WAIT abort counter enabled by SPI_ARB_TIMEOUT_EN.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic         clk,
   input logic         rst_n,
   spi_arbiter_if.master bus
);

   localparam int IW = idx_w(NUM_REQ);

   arb_state_t            state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         win_q, win_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic                  start_q, start_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [IW-1:0]         arb_win;
   logic                  arb_any;
   logic [IW-1:0]         ptr_nxt;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = idx_w(TIMEOUT_CYCLES);
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req (bus.req),
      .ptr (ptr_q),
      .win (arb_win),
      .any (arb_any)
   );

   assign ptr_nxt = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      grant_d = grant_q;
      ack_d   = '0;
      rx_d    = rx_q;
      start_d = 1'b0;
      tx_d    = tx_q;
`ifdef SPI_ARB_TIMEOUT_EN
      err_d   = 1'b0;
      cnt_d   = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               win_d   = arb_win;
               grant_d = NUM_REQ'(1) << arb_win;
               for (int i = 0; i < NUM_REQ; i++)
                  if (arb_win == IW'(i))
                     tx_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.m_busy) begin
               start_d = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (bus.m_done) begin
               rx_d    = bus.m_rx_data;
               ack_d   = grant_q;
               grant_d = '0;
               ptr_d   = ptr_nxt;
               state_d = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               // abort: no master byte, report err alongside ack
               rx_d    = '0;
               ack_d   = grant_q;
               err_d   = 1'b1;
               grant_d = '0;
               ptr_d   = ptr_nxt;
               state_d = IDLE;
               cnt_d   = '0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         rx_q    <= '0;
         start_q <= 1'b0;
         tx_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         rx_q    <= rx_d;
         start_q <= start_d;
         tx_q    <= tx_d;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.ack       = ack_q;
   assign bus.rx_data   = rx_q;
   assign bus.m_start   = start_q;
   assign bus.m_tx_data = tx_q;
   assign bus.spi_cs_n  = {NUM_REQ{bus.m_cs_n}} | ~grant_q;

`ifdef SPI_ARB_TIMEOUT_EN
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule
